wb_stage_regfile: RTL and testbench
===================================

// Module: wb_stage_regfile
// PURPOSE
//  Writeback-stage consumer of the M/W pipeline register outputs.
//  - Selects the writeback value: ALU result, extended load data or link address.
//  - Performs byte/halfword load extension and writes the 32x32 general register file (GRF).
//  - Serves the two D-stage read ports, with optional same-cycle write-to-read bypass.
//  - Exports the W-stage forwarding source for the hazard unit.
// PARAMETERS
//  BYPASS      1      1: a read of the register being written this cycle returns the new value; 0: returns the stored value
//  LINK_OFFSET 32'd4  added to pc_4_w for link writes (result = PC+8, delay-slot convention)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset        in   1   synchronous, active-high
//  reg_write_w  in   1   write enable from M/W register
//  memto_reg_w  in   2   00 ALU, 01 load, 10 link, 11 reserved (treated as 00)
//  loadop_w     in   3   000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, others treated as lw
//  rd_w         in   32  raw word read from data memory
//  alu_out_w    in   32  ALU result / memory address (bits [1:0] select byte/half)
//  pc_4_w       in   32  PC+4 of the instruction in W
//  tnew_w       in   2   remaining cycles until the result is ready (0 in W for valid producers)
//  awrite_w     in   5   destination register number
//  ra1, ra2     in   5   D-stage read addresses
//  rd1, rd2     out  32  D-stage read data
//  fwd_en_w     out  1   W result is forwardable this cycle
//  fwd_addr_w   out  5   forwarded destination (0 when fwd_en_w=0)
//  fwd_data_w   out  32  forwarded value (= wb_data)
// BEHAVIOUR
//  - Reset: all 31 writable registers cleared to 0 on the first posedge with reset=1.
//    fwd_* outputs are combinational from the W inputs; after reset the M/W register
//    holds zeros, so fwd_en_w=0, fwd_addr_w=0 and fwd_data_w=0.
//  - Write: wen = reg_write_w && (awrite_w != 0). On posedge with wen and !reset,
//    GRF[awrite_w] <= wb_data. Latency is 1 cycle into storage.
//  - Reset has priority over a simultaneous write; the write is lost.
//  - Register $0 reads 0 always; writes to $0 are discarded.
//  - Load extension (a = alu_out_w[1:0]):
//    - lw:  rd_w, with a ignored.
//    - lb/lbu: byte rd_w[8a+7:8a], sign-/zero-extended.
//    - lh/lhu: half rd_w[15:0] if a[1]=0, else rd_w[31:16], sign-/zero-extended; a[0] ignored.
//  - wb_data mux:
//    - 00 -> alu_out_w
//    - 01 -> extended load value
//    - 10 -> pc_4_w + LINK_OFFSET, modulo 2^32
//    - 11 -> alu_out_w
//  - Reads are combinational: rdN = (raN==0) ? 0 : (BYPASS && wen && raN==awrite_w) ? wb_data : GRF[raN].
//    Both ports are independent; both may hit the bypass simultaneously.
//  - Forwarding: fwd_en_w = wen && (tnew_w==0); fwd_addr_w = fwd_en_w ? awrite_w : 0.
//    A W-stage entry with tnew_w != 0 is never forwarded.
//  - No other state besides the GRF; no stall input. Every cycle's W inputs are consumed exactly once.
//  - Back-to-back writes to the same register: the last write wins; the intermediate value is
//    visible via bypass in its own cycle only.
// TESTING
//  1. reset=1 for 2 cycles, then read all 32 addresses -> every rd1/rd2 = 0; fwd_en_w=0.
//  2. reg_write_w=1, awrite_w=5, memto_reg_w=00, alu_out_w=32'h1234_5678 -> same cycle rd1(ra1=5)=32'h1234_5678 (BYPASS=1); next cycle, with inputs idle, rd1=32'h1234_5678.
//  3. memto_reg_w=01, rd_w=32'h80FF_7F01, alu_out_w=..._0003, lb -> GRF=32'hFFFF_FF80; lbu -> 32'h0000_0080; lh with a=2 -> 32'hFFFF_80FF; lhu with a=0 -> 32'h0000_7F01.
//  4. Write to $0 with alu_out_w=32'hDEAD_BEEF -> rd1(ra1=0)=0, fwd_en_w=0; memto_reg_w=10, pc_4_w=32'h0000_3004, awrite_w=31 -> $31=32'h0000_3008; pc_4_w=32'hFFFF_FFFC -> $31=32'h0000_0000 (wrap).
//  5. Write $7 with tnew_w=1 -> fwd_en_w=0 but GRF[7] still updated; assert reset together with a write to $7 -> $7 reads 0 after the edge.

Source files
------------

// File: rtl/wb_stage_regfile.sv
// Writeback stage: load extension, wb_data mux, 32x32 GRF,
// two bypassed D-stage read ports and the W-stage forward source.
//
// Ports:
//   clk, reset                 clock, sync active-high reset
//   reg_write_w, awrite_w      write enable / destination
//   memto_reg_w                00 ALU, 01 load, 10 link, 11 ALU
//   loadop_w, rd_w             load kind / raw memory word
//   alu_out_w, pc_4_w          ALU result (byte addr) / PC+4
//   tnew_w                     cycles until result ready
//   ra1, ra2 -> rd1, rd2       D-stage read ports
//   fwd_en_w/addr_w/data_w     W-stage forwarding source
module wb_stage_regfile #(
  parameter bit          BYPASS      = 1'b1,
  parameter logic [31:0] LINK_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write_w,
  input  logic [1:0]  memto_reg_w,
  input  logic [2:0]  loadop_w,
  input  logic [31:0] rd_w,
  input  logic [31:0] alu_out_w,
  input  logic [31:0] pc_4_w,
  input  logic [1:0]  tnew_w,
  input  logic [4:0]  awrite_w,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        fwd_en_w,
  output logic [4:0]  fwd_addr_w,
  output logic [31:0] fwd_data_w
);

  logic        w_wen;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;
  logic [31:0] w_wb_data;
  logic [31:0] r_grf [32];

  always_comb begin
    w_byte = rd_w[7:0];
    unique case (alu_out_w[1:0])
      2'd0: w_byte = rd_w[7:0];
      2'd1: w_byte = rd_w[15:8];
      2'd2: w_byte = rd_w[23:16];
      2'd3: w_byte = rd_w[31:24];
    endcase
  end

  // a[0] is ignored for halfword accesses
  assign w_half = alu_out_w[1] ? rd_w[31:16]
                               : rd_w[15:0];

  always_comb begin
    w_ld_data = rd_w;
    case (loadop_w)
      3'b001:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_ld_data = {24'd0, w_byte};
      3'b011:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_data = {16'd0, w_half};
      default: w_ld_data = rd_w;
    endcase
  end

  always_comb begin
    w_wb_data = alu_out_w;
    unique case (memto_reg_w)
      2'b01:   w_wb_data = w_ld_data;
      2'b10:   w_wb_data = pc_4_w + LINK_OFFSET;
      default: w_wb_data = alu_out_w;
    endcase
  end

  assign w_wen = reg_write_w && (awrite_w != 5'd0);

  // reset wins over a coincident write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_grf[i] <= '0;
      end
    end else if (w_wen) begin
      r_grf[awrite_w] <= w_wb_data;
    end
  end

  always_comb begin
    rd1 = r_grf[ra1];
    if (ra1 == 5'd0) begin
      rd1 = '0;
    end else if (BYPASS && w_wen
                 && (ra1 == awrite_w)) begin
      rd1 = w_wb_data;
    end
  end

  always_comb begin
    rd2 = r_grf[ra2];
    if (ra2 == 5'd0) begin
      rd2 = '0;
    end else if (BYPASS && w_wen
                 && (ra2 == awrite_w)) begin
      rd2 = w_wb_data;
    end
  end

  assign fwd_en_w   = w_wen && (tnew_w == 2'd0);
  assign fwd_addr_w = fwd_en_w ? awrite_w : 5'd0;
  assign fwd_data_w = w_wb_data;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Bench for wb_stage_regfile: scoreboard of
// expected GRF contents drained by read-back.
module tb_wb_stage_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write_w;
  logic [1:0]  memto_reg_w;
  logic [2:0]  loadop_w;
  logic [31:0] rd_w;
  logic [31:0] alu_out_w;
  logic [31:0] pc_4_w;
  logic [1:0]  tnew_w;
  logic [4:0]  awrite_w;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        fwd_en_w;
  logic [4:0]  fwd_addr_w;
  logic [31:0] fwd_data_w;

  always #5 clk = ~clk;

  wb_stage_regfile #(
    .BYPASS(1'b1),
    .LINK_OFFSET(32'd4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reg_write_w(reg_write_w),
    .memto_reg_w(memto_reg_w),
    .loadop_w(loadop_w),
    .rd_w(rd_w),
    .alu_out_w(alu_out_w),
    .pc_4_w(pc_4_w),
    .tnew_w(tnew_w),
    .awrite_w(awrite_w),
    .ra1(ra1),
    .ra2(ra2),
    .rd1(rd1),
    .rd2(rd2),
    .fwd_en_w(fwd_en_w),
    .fwd_addr_w(fwd_addr_w),
    .fwd_data_w(fwd_data_w)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] v;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mdl [32];
  logic [31:0] exp_wb;
  logic        exp_wen;
  int          n_pass = 0;
  int          n_tot  = 0;

  function automatic logic [31:0] ref_wb(
    input logic [1:0]  mt,
    input logic [2:0]  lop,
    input logic [31:0] rdw,
    input logic [31:0] alu,
    input logic [31:0] pc4
  );
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld;
    sh = rdw >> (8 * alu[1:0]);
    b  = sh[7:0];
    h  = alu[1] ? rdw[31:16] : rdw[15:0];
    if (lop == 3'd1)
      ld = {{24{b[7]}}, b};
    else if (lop == 3'd2)
      ld = {24'd0, b};
    else if (lop == 3'd3)
      ld = {{16{h[15]}}, h};
    else if (lop == 3'd4)
      ld = {16'd0, h};
    else
      ld = rdw;
    if (mt == 2'b01) return ld;
    if (mt == 2'b10) return pc4 + 32'd4;
    return alu;
  endfunction

  function automatic logic [31:0] exp_rd(
    input logic [4:0] ra
  );
    if (ra == 5'd0) return 32'd0;
    if (exp_wen && ra == awrite_w) return exp_wb;
    return mdl[ra];
  endfunction

  task automatic set_idle;
    reg_write_w = 1'b0;
    memto_reg_w = 2'b00;
    loadop_w    = 3'd0;
    rd_w        = 32'd0;
    alu_out_w   = 32'd0;
    pc_4_w      = 32'd0;
    tnew_w      = 2'd0;
    awrite_w    = 5'd0;
    exp_wen     = 1'b0;
    exp_wb      = 32'd0;
  endtask

  task automatic drive_w(
    input logic        we,
    input logic [4:0]  aw,
    input logic [1:0]  mt,
    input logic [2:0]  lop,
    input logic [31:0] rdw,
    input logic [31:0] alu,
    input logic [31:0] pc4,
    input logic [1:0]  tn,
    input logic [4:0]  r1,
    input logic [4:0]  r2
  );
    @(negedge clk);
    reg_write_w = we;
    awrite_w    = aw;
    memto_reg_w = mt;
    loadop_w    = lop;
    rd_w        = rdw;
    alu_out_w   = alu;
    pc_4_w      = pc4;
    tnew_w      = tn;
    ra1         = r1;
    ra2         = r2;
    exp_wb  = ref_wb(mt, lop, rdw, alu, pc4);
    exp_wen = we && (aw != 5'd0);
    if (exp_wen) begin
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].a == aw) sb.delete(i);
      sb.push_back('{aw, exp_wb});
    end
    #1;
  endtask

  task automatic commit;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    end else if (exp_wen) begin
      mdl[awrite_w] = exp_wb;
    end
  endtask

  task automatic drain_sb;
    sb_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      set_idle();
      e   = sb.pop_front();
      ra1 = e.a;
      ra2 = e.a;
      #1;
      n_tot++;
      if (rd1 !== e.v)
        $display("FAIL sb_rd1 r%0d got %h exp %h",
                 e.a, rd1, e.v);
      else n_pass++;
      n_tot++;
      if (rd2 !== e.v)
        $display("FAIL sb_rd2 r%0d got %h exp %h",
                 e.a, rd2, e.v);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    set_idle();
    ra1   = 5'd0;
    ra2   = 5'd0;
    reset = 1'b1;
    commit();
    commit();
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      n_tot++;
      if (rd1 !== 32'd0)
        $display("FAIL rst_rd1 r%0d got %h exp 0",
                 i, rd1);
      else n_pass++;
      n_tot++;
      if (rd2 !== 32'd0)
        $display("FAIL rst_rd2 r%0d got %h exp 0",
                 31 - i, rd2);
      else n_pass++;
    end
    n_tot++;
    if ({fwd_en_w, fwd_addr_w, fwd_data_w} !== '0)
      $display("FAIL rst_fwd got %b/%h/%h exp 0",
               fwd_en_w, fwd_addr_w, fwd_data_w);
    else n_pass++;
  endtask

  task automatic test_alu_write;
    drive_w(1'b1, 5'd5, 2'b00, 3'd0, 32'd0,
            32'h1234_5678, 32'd0, 2'd0,
            5'd5, 5'd6);
    n_tot++;
    if (rd1 !== 32'h1234_5678)
      $display("FAIL alu_byp got %h exp %h",
               rd1, 32'h1234_5678);
    else n_pass++;
    n_tot++;
    if (rd2 !== 32'd0)
      $display("FAIL alu_other got %h exp 0", rd2);
    else n_pass++;
    n_tot++;
    if (fwd_en_w !== 1'b1 || fwd_addr_w !== 5'd5
        || fwd_data_w !== 32'h1234_5678)
      $display("FAIL alu_fwd got %b/%h/%h exp 1/05/%h",
               fwd_en_w, fwd_addr_w, fwd_data_w,
               32'h1234_5678);
    else n_pass++;
    commit();
    drain_sb();
  endtask

  task automatic test_loads;
    logic [31:0] w;
    logic [31:0] e [4];
    logic [2:0]  op [4];
    logic [31:0] ad [4];
    w = 32'h80FF_7F01;
    e[0] = 32'hFFFF_FF80; op[0] = 3'd1;
    e[1] = 32'h0000_0080; op[1] = 3'd2;
    e[2] = 32'hFFFF_80FF; op[2] = 3'd3;
    e[3] = 32'h0000_7F01; op[3] = 3'd4;
    ad[0] = 32'h1000_0003;
    ad[1] = 32'h1000_0003;
    ad[2] = 32'h1000_0002;
    ad[3] = 32'h1000_0000;
    for (int i = 0; i < 4; i++) begin
      drive_w(1'b1, 5'(10 + i), 2'b01, op[i], w,
              ad[i], 32'd0, 2'd0,
              5'(10 + i), 5'd5);
      n_tot++;
      if (rd1 !== e[i])
        $display("FAIL load%0d got %h exp %h",
                 i, rd1, e[i]);
      else n_pass++;
      commit();
    end
    drain_sb();
  endtask

  task automatic test_zero_link;
    drive_w(1'b1, 5'd0, 2'b00, 3'd0, 32'd0,
            32'hDEAD_BEEF, 32'd0, 2'd0,
            5'd0, 5'd0);
    n_tot++;
    if (rd1 !== 32'd0 || fwd_en_w !== 1'b0
        || fwd_addr_w !== 5'd0)
      $display("FAIL r0_wr got %h/%b/%h exp 0/0/0",
               rd1, fwd_en_w, fwd_addr_w);
    else n_pass++;
    commit();
    @(negedge clk);
    set_idle();
    ra1 = 5'd0;
    #1;
    n_tot++;
    if (rd1 !== 32'd0)
      $display("FAIL r0_hold got %h exp 0", rd1);
    else n_pass++;
    drive_w(1'b1, 5'd31, 2'b10, 3'd0, 32'd0,
            32'd0, 32'h0000_3004, 2'd0,
            5'd1, 5'd2);
    commit();
    drain_sb();
    n_tot++;
    if (rd1 !== 32'h0000_3008)
      $display("FAIL link got %h exp %h",
               rd1, 32'h0000_3008);
    else n_pass++;
    drive_w(1'b1, 5'd31, 2'b10, 3'd0, 32'd0,
            32'd0, 32'hFFFF_FFFC, 2'd0,
            5'd31, 5'd31);
    n_tot++;
    if (rd2 !== 32'd0)
      $display("FAIL link_wrap got %h exp 0", rd2);
    else n_pass++;
    commit();
    drain_sb();
  endtask

  task automatic test_tnew_reset;
    drive_w(1'b1, 5'd7, 2'b00, 3'd0, 32'd0,
            32'h0000_A5A5, 32'd0, 2'd1,
            5'd7, 5'd7);
    n_tot++;
    if (fwd_en_w !== 1'b0 || fwd_addr_w !== 5'd0)
      $display("FAIL tnew_fwd got %b/%h exp 0/00",
               fwd_en_w, fwd_addr_w);
    else n_pass++;
    commit();
    drain_sb();
    drive_w(1'b1, 5'd7, 2'b00, 3'd0, 32'd0,
            32'h0BAD_F00D, 32'd0, 2'd0,
            5'd7, 5'd0);
    reset = 1'b1;
    commit();
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    set_idle();
    ra1 = 5'd7;
    ra2 = 5'd13;
    #1;
    n_tot++;
    if (rd1 !== 32'd0)
      $display("FAIL rst_wr got %h exp 0", rd1);
    else n_pass++;
    n_tot++;
    if (rd2 !== 32'd0)
      $display("FAIL rst_clr got %h exp 0", rd2);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    drive_w(1'b1, 5'd9, 2'b00, 3'd0, 32'd0,
            32'h1111_1111, 32'd0, 2'd0,
            5'd9, 5'd9);
    n_tot++;
    if (rd1 !== 32'h1111_1111
        || rd2 !== 32'h1111_1111)
      $display("FAIL b2b_1 got %h/%h exp %h",
               rd1, rd2, 32'h1111_1111);
    else n_pass++;
    commit();
    drive_w(1'b1, 5'd9, 2'b00, 3'd0, 32'd0,
            32'h2222_2222, 32'd0, 2'd0,
            5'd9, 5'd9);
    n_tot++;
    if (rd1 !== 32'h2222_2222)
      $display("FAIL b2b_2 got %h exp %h",
               rd1, 32'h2222_2222);
    else n_pass++;
    commit();
    drain_sb();
  endtask

  task automatic test_random;
    logic [4:0] aw;
    logic [4:0] r2;
    logic [31:0] e1;
    logic [31:0] e2;
    for (int i = 0; i < 60; i++) begin
      aw = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      drive_w(1'($urandom_range(0, 1)), aw,
              2'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)),
              $urandom, $urandom, $urandom,
              2'($urandom_range(0, 3)), aw, r2);
      e1 = exp_rd(aw);
      e2 = exp_rd(r2);
      n_tot++;
      if (rd1 !== e1 || rd2 !== e2)
        $display("FAIL rnd%0d rd got %h/%h exp %h/%h",
                 i, rd1, rd2, e1, e2);
      else n_pass++;
      n_tot++;
      if (fwd_en_w !== (exp_wen && tnew_w == 2'd0)
          || fwd_data_w !== exp_wb)
        $display("FAIL rnd%0d fwd got %b/%h exp %h",
                 i, fwd_en_w, fwd_data_w, exp_wb);
      else n_pass++;
      commit();
    end
    drain_sb();
  endtask

  initial begin
    reset = 1'b1;
    ra1   = 5'd0;
    ra2   = 5'd0;
    set_idle();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    test_reset();
    test_alu_write();
    test_loads();
    test_zero_link();
    test_tnew_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp done");
    $fatal(1, "timeout");
  end

endmodule
